// File: rtl/scariv_bru_pred_upd_queue_if.sv
// Bundle between the BRU EX3 update source, the predictor trainer and the update queue.
// The queue is the slave side; the upstream/consumer environment is the master side.
interface scariv_bru_pred_upd_queue_if #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned VADDR_W  = 39,
    parameter int unsigned CMT_ID_W = 6,
    parameter int unsigned BHR_W    = 16,
    parameter int unsigned GIDX_W   = 10
);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned DROP_W = 8;

    logic                upd_valid;
    logic                upd_dead;
    logic                upd_mispredict;
    logic                upd_taken;
    logic                upd_is_cond;
    logic                upd_is_call;
    logic                upd_is_ret;
    logic                upd_is_rvc;
    logic                upd_btb_not_hit;
    logic [VADDR_W-1:0]  upd_pc_vaddr;
    logic [VADDR_W-1:0]  upd_target_vaddr;
    logic [1:0]          upd_bim_value;
    logic [BHR_W-1:0]    upd_gshare_bhr;
    logic [GIDX_W-1:0]   upd_gshare_index;
    logic [CMT_ID_W-1:0] upd_cmt_id;

    logic                flush;

    logic                redirect_valid;
    logic [VADDR_W-1:0]  redirect_vaddr;
    logic [CMT_ID_W-1:0] redirect_cmt_id;

    logic                train_valid;
    logic                train_ready;
    logic [VADDR_W-1:0]  train_pc_vaddr;
    logic [VADDR_W-1:0]  train_target_vaddr;
    logic                train_taken;
    logic                train_is_cond;
    logic                train_is_call;
    logic                train_is_ret;
    logic                train_is_rvc;
    logic                train_btb_not_hit;
    logic [BHR_W-1:0]    train_gshare_bhr;
    logic [GIDX_W-1:0]   train_gshare_index;
    logic                train_mispredict;
    logic [1:0]          train_bim_next;

    logic [CNT_W-1:0]    count;
    logic [DROP_W-1:0]   drop_cnt;

    modport slave (
        input  upd_valid, upd_dead, upd_mispredict, upd_taken, upd_is_cond, upd_is_call,
               upd_is_ret, upd_is_rvc, upd_btb_not_hit, upd_pc_vaddr, upd_target_vaddr,
               upd_bim_value, upd_gshare_bhr, upd_gshare_index, upd_cmt_id,
               flush, train_ready,
        output redirect_valid, redirect_vaddr, redirect_cmt_id,
               train_valid, train_pc_vaddr, train_target_vaddr, train_taken, train_is_cond,
               train_is_call, train_is_ret, train_is_rvc, train_btb_not_hit,
               train_gshare_bhr, train_gshare_index, train_mispredict, train_bim_next,
               count, drop_cnt
    );

    modport master (
        output upd_valid, upd_dead, upd_mispredict, upd_taken, upd_is_cond, upd_is_call,
               upd_is_ret, upd_is_rvc, upd_btb_not_hit, upd_pc_vaddr, upd_target_vaddr,
               upd_bim_value, upd_gshare_bhr, upd_gshare_index, upd_cmt_id,
               flush, train_ready,
        input  redirect_valid, redirect_vaddr, redirect_cmt_id,
               train_valid, train_pc_vaddr, train_target_vaddr, train_taken, train_is_cond,
               train_is_call, train_is_ret, train_is_rvc, train_btb_not_hit,
               train_gshare_bhr, train_gshare_index, train_mispredict, train_bim_next,
               count, drop_cnt
    );
endinterface

// File: rtl/scariv_bru_pred_upd_queue.sv
// FIFO of BRU EX3 resolutions replayed to predictor training, plus a one-cycle
// registered frontend redirect for accepted mispredicts.
module scariv_bru_pred_upd_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned VADDR_W  = 39,
    parameter int unsigned CMT_ID_W = 6,
    parameter int unsigned BHR_W    = 16,
    parameter int unsigned GIDX_W   = 10
) (
    input  logic i_clk,
    input  logic i_reset_n,
    scariv_bru_pred_upd_queue_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned DROP_W = 8;

    typedef struct packed {
        logic [VADDR_W-1:0] pc_vaddr;
        logic [VADDR_W-1:0] target_vaddr;
        logic               taken;
        logic               is_cond;
        logic               is_call;
        logic               is_ret;
        logic               is_rvc;
        logic               btb_not_hit;
        logic [1:0]         bim_value;
        logic [BHR_W-1:0]   gshare_bhr;
        logic [GIDX_W-1:0]  gshare_index;
        logic               mispredict;
    } entry_t;

    entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]    head_q;
    logic [PTR_W-1:0]    tail_q;
    logic [CNT_W-1:0]    count_q;
    logic [DROP_W-1:0]   drop_cnt_q;
    logic                redirect_valid_q;
    logic [VADDR_W-1:0]  redirect_vaddr_q;
    logic [CMT_ID_W-1:0] redirect_cmt_id_q;

    logic   acc_c;
    logic   deq_c;
    logic   space_c;
    logic   enq_c;
    logic   drop_c;
    logic   valid_c;
    entry_t new_entry_c;
    entry_t head_entry_c;
    logic [1:0] bim_next_c;

    // Space is judged after a same-cycle dequeue, so a full queue can stream.
    always_comb begin
        valid_c = (count_q != '0);
        acc_c   = bus.upd_valid & ~bus.upd_dead & ~bus.flush;
        deq_c   = valid_c & bus.train_ready;
        space_c = (count_q != CNT_W'(DEPTH)) | deq_c;
        enq_c   = acc_c & space_c;
        drop_c  = acc_c & ~space_c;

        new_entry_c.pc_vaddr     = bus.upd_pc_vaddr;
        new_entry_c.target_vaddr = bus.upd_target_vaddr;
        new_entry_c.taken        = bus.upd_taken;
        new_entry_c.is_cond      = bus.upd_is_cond;
        new_entry_c.is_call      = bus.upd_is_call;
        new_entry_c.is_ret       = bus.upd_is_ret;
        new_entry_c.is_rvc       = bus.upd_is_rvc;
        new_entry_c.btb_not_hit  = bus.upd_btb_not_hit;
        new_entry_c.bim_value    = bus.upd_bim_value;
        new_entry_c.gshare_bhr   = bus.upd_gshare_bhr;
        new_entry_c.gshare_index = bus.upd_gshare_index;
        new_entry_c.mispredict   = bus.upd_mispredict;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (enq_c) begin
            mem_q[tail_q] <= new_entry_c;
        end
    end

    // Pointers and occupancy; flush empties the queue regardless of handshakes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_c) tail_q <= tail_q + PTR_W'(1);
            if (deq_c) head_q <= head_q + PTR_W'(1);
            case ({enq_c, deq_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            drop_cnt_q <= '0;
        end else if (drop_c && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            redirect_valid_q  <= 1'b0;
            redirect_vaddr_q  <= '0;
            redirect_cmt_id_q <= '0;
        end else begin
            redirect_valid_q <= acc_c & bus.upd_mispredict;
            if (acc_c && bus.upd_mispredict) begin
                redirect_vaddr_q  <= bus.upd_target_vaddr;
                redirect_cmt_id_q <= bus.upd_cmt_id;
            end
        end
    end

    // Training view of the head; the counter update is held at 0 when empty.
    always_comb begin
        head_entry_c = mem_q[head_q];
        bim_next_c   = 2'b00;
        if (valid_c) begin
            if (!head_entry_c.is_cond) begin
                bim_next_c = 2'b11;
            end else if (head_entry_c.taken) begin
                bim_next_c = (head_entry_c.bim_value == 2'b11) ? 2'b11
                                                               : 2'(head_entry_c.bim_value + 2'd1);
            end else begin
                bim_next_c = (head_entry_c.bim_value == 2'b00) ? 2'b00
                                                               : 2'(head_entry_c.bim_value - 2'd1);
            end
        end
    end

    assign bus.train_valid        = valid_c;
    assign bus.train_pc_vaddr     = head_entry_c.pc_vaddr;
    assign bus.train_target_vaddr = head_entry_c.target_vaddr;
    assign bus.train_taken        = head_entry_c.taken;
    assign bus.train_is_cond      = head_entry_c.is_cond;
    assign bus.train_is_call      = head_entry_c.is_call;
    assign bus.train_is_ret       = head_entry_c.is_ret;
    assign bus.train_is_rvc       = head_entry_c.is_rvc;
    assign bus.train_btb_not_hit  = head_entry_c.btb_not_hit;
    assign bus.train_gshare_bhr   = head_entry_c.gshare_bhr;
    assign bus.train_gshare_index = head_entry_c.gshare_index;
    assign bus.train_mispredict   = head_entry_c.mispredict;
    assign bus.train_bim_next     = bim_next_c;

    assign bus.redirect_valid  = redirect_valid_q;
    assign bus.redirect_vaddr  = redirect_vaddr_q;
    assign bus.redirect_cmt_id = redirect_cmt_id_q;
    assign bus.count           = count_q;
    assign bus.drop_cnt        = drop_cnt_q;
endmodule

// File: tb/tb_scariv_bru_pred_upd_queue.sv
// Directed, table-driven bench for the BRU predictor-update queue (DEPTH=4).
module tb_scariv_bru_pred_upd_queue;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned VADDR_W  = 39;
    localparam int unsigned CMT_ID_W = 6;
    localparam int unsigned BHR_W    = 16;
    localparam int unsigned GIDX_W   = 10;

    logic clk;
    logic rst_n;

    scariv_bru_pred_upd_queue_if #(
        .DEPTH(DEPTH), .VADDR_W(VADDR_W), .CMT_ID_W(CMT_ID_W), .BHR_W(BHR_W), .GIDX_W(GIDX_W)
    ) bus ();

    scariv_bru_pred_upd_queue #(
        .DEPTH(DEPTH), .VADDR_W(VADDR_W), .CMT_ID_W(CMT_ID_W), .BHR_W(BHR_W), .GIDX_W(GIDX_W)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v, d, m, f, r, tk, cond;
        logic [1:0]   bim;
        logic [38:0]  pc, tgt;
        int           e_cnt;
        logic         e_tv;
        logic [38:0]  e_pc;
        logic [1:0]   e_bn;
        logic         e_rv;
        logic [38:0]  e_rva;
        int           e_drop;
    } vec_t;

    vec_t vecs [16];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic v, logic d, logic m, logic f, logic r,
                                logic [38:0] pc, logic [38:0] tgt, logic tk, logic cond,
                                logic [1:0] bim, int e_cnt, logic e_tv, logic [38:0] e_pc,
                                logic [1:0] e_bn, logic e_rv, logic [38:0] e_rva, int e_drop);
        vec_t x;
        x.v = v; x.d = d; x.m = m; x.f = f; x.r = r; x.pc = pc; x.tgt = tgt;
        x.tk = tk; x.cond = cond; x.bim = bim; x.e_cnt = e_cnt; x.e_tv = e_tv;
        x.e_pc = e_pc; x.e_bn = e_bn; x.e_rv = e_rv; x.e_rva = e_rva; x.e_drop = e_drop;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic d, input logic m, input logic f,
                         input logic r, input logic [38:0] pc, input logic [38:0] tgt,
                         input logic tk, input logic cond, input logic [1:0] bim);
        bus.upd_valid        = v;
        bus.upd_dead         = d;
        bus.upd_mispredict   = m;
        bus.flush            = f;
        bus.train_ready      = r;
        bus.upd_pc_vaddr     = pc;
        bus.upd_target_vaddr = tgt;
        bus.upd_taken        = tk;
        bus.upd_is_cond      = cond;
        bus.upd_bim_value    = bim;
        bus.upd_cmt_id       = pc[5:0];
        bus.upd_gshare_bhr   = pc[15:0];
        bus.upd_gshare_index = pc[11:2];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [38:0] mq [$];
    int          exp_drop;
    logic        vld;
    logic        rdy;
    logic [38:0] wpc;

    initial begin
        bus.upd_is_call     = 1'b0;
        bus.upd_is_ret      = 1'b0;
        bus.upd_is_rvc      = 1'b0;
        bus.upd_btb_not_hit = 1'b0;

        //    v  d  m  f  r  pc          tgt         tk cond bim  cnt tv  head pc     bn  rv  rva         drop
        vecs[0]  = mk(1, 0, 0, 0, 0, 39'h1000, 39'h2000, 1, 1, 2'd1, 1, 1, 39'h1000, 2'd2, 0, 39'h0,    0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 39'h1004, 39'h2004, 0, 1, 2'd0, 2, 1, 39'h1000, 2'd2, 0, 39'h0,    0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 39'h1008, 39'h2008, 1, 0, 2'd1, 3, 1, 39'h1000, 2'd2, 0, 39'h0,    0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 39'h100c, 39'h200c, 1, 1, 2'd3, 4, 1, 39'h1000, 2'd2, 0, 39'h0,    0);
        vecs[4]  = mk(1, 0, 1, 0, 0, 39'h1010, 39'h2040, 1, 1, 2'd1, 4, 1, 39'h1000, 2'd2, 1, 39'h2040, 1);
        vecs[5]  = mk(0, 0, 0, 0, 1, 39'h0,    39'h0,    0, 0, 2'd0, 3, 1, 39'h1004, 2'd0, 0, 39'h0,    1);
        vecs[6]  = mk(1, 0, 0, 0, 1, 39'h1014, 39'h2014, 1, 1, 2'd2, 3, 1, 39'h1008, 2'd3, 0, 39'h0,    1);
        vecs[7]  = mk(1, 1, 1, 0, 0, 39'h1018, 39'h2018, 1, 1, 2'd1, 3, 1, 39'h1008, 2'd3, 0, 39'h0,    1);
        vecs[8]  = mk(0, 0, 0, 0, 1, 39'h0,    39'h0,    0, 0, 2'd0, 2, 1, 39'h100c, 2'd3, 0, 39'h0,    1);
        vecs[9]  = mk(1, 0, 1, 0, 0, 39'h1018, 39'h3000, 1, 1, 2'd1, 3, 1, 39'h100c, 2'd3, 1, 39'h3000, 1);
        vecs[10] = mk(1, 0, 0, 0, 0, 39'h101c, 39'h201c, 1, 1, 2'd1, 4, 1, 39'h100c, 2'd3, 0, 39'h0,    1);
        vecs[11] = mk(1, 0, 0, 0, 1, 39'h1020, 39'h2020, 0, 1, 2'd1, 4, 1, 39'h1014, 2'd3, 0, 39'h0,    1);
        vecs[12] = mk(1, 0, 1, 1, 1, 39'h1024, 39'h4000, 1, 1, 2'd1, 0, 0, 39'h0,    2'd0, 0, 39'h0,    1);
        vecs[13] = mk(0, 0, 0, 0, 0, 39'h0,    39'h0,    0, 0, 2'd0, 0, 0, 39'h0,    2'd0, 0, 39'h0,    1);
        vecs[14] = mk(1, 0, 0, 0, 0, 39'h1100, 39'h2100, 0, 1, 2'd0, 1, 1, 39'h1100, 2'd0, 0, 39'h0,    1);
        vecs[15] = mk(0, 0, 0, 0, 1, 39'h0,    39'h0,    0, 0, 2'd0, 0, 0, 39'h0,    2'd0, 0, 39'h0,    1);

        // Reset held with an active mispredicting update on the inputs.
        rst_n = 1'b0;
        drive(1, 0, 1, 0, 1, 39'h7000, 39'h7fff, 1, 1, 2'd1);
        repeat (3) step();
        chk("rst_count",     64'(bus.count), 64'd0);
        chk("rst_drop",      64'(bus.drop_cnt), 64'd0);
        chk("rst_redir_v",   64'(bus.redirect_valid), 64'd0);
        chk("rst_redir_va",  64'(bus.redirect_vaddr), 64'd0);
        chk("rst_redir_id",  64'(bus.redirect_cmt_id), 64'd0);
        chk("rst_train_v",   64'(bus.train_valid), 64'd0);
        chk("rst_train_pc",  64'(bus.train_pc_vaddr), 64'd0);
        chk("rst_bim_next",  64'(bus.train_bim_next), 64'd0);
        drive(0, 0, 0, 0, 0, 39'h0, 39'h0, 0, 0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_count", 64'(bus.count), 64'd0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].m, vecs[i].f, vecs[i].r,
                  vecs[i].pc, vecs[i].tgt, vecs[i].tk, vecs[i].cond, vecs[i].bim);
            step();
            chk($sformatf("v%0d_count", i), 64'(bus.count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_train_v", i), 64'(bus.train_valid), 64'(vecs[i].e_tv));
            if (vecs[i].e_tv) begin
                chk($sformatf("v%0d_head_pc", i), 64'(bus.train_pc_vaddr), 64'(vecs[i].e_pc));
                chk($sformatf("v%0d_bim_next", i), 64'(bus.train_bim_next), 64'(vecs[i].e_bn));
            end
            chk($sformatf("v%0d_redir_v", i), 64'(bus.redirect_valid), 64'(vecs[i].e_rv));
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d_redir_va", i), 64'(bus.redirect_vaddr), 64'(vecs[i].e_rva));
                chk($sformatf("v%0d_redir_id", i), 64'(bus.redirect_cmt_id), 64'(vecs[i].pc[5:0]));
            end
            chk($sformatf("v%0d_drop", i), 64'(bus.drop_cnt), 64'(vecs[i].e_drop));
        end

        // Ten entries streamed through with a stuttering consumer; pointers wrap.
        exp_drop = 1;
        mq.delete();
        for (int c = 0; c < 16; c++) begin
            vld = (c < 10);
            rdy = ((c % 3) != 0);
            wpc = 39'h5000 + 39'(c * 4);
            drive(vld, 0, 0, 0, rdy, wpc, 39'h6000, 1, 1, 2'd1);
            chk($sformatf("wrap%0d_train_v", c), 64'(bus.train_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk($sformatf("wrap%0d_head_pc", c), 64'(bus.train_pc_vaddr), 64'(mq[0]));
                if (rdy) void'(mq.pop_front());
            end
            if (vld) begin
                if (mq.size() < int'(DEPTH)) mq.push_back(wpc);
                else exp_drop++;
            end
            step();
        end
        chk("wrap_count", 64'(bus.count), 64'(mq.size()));
        chk("wrap_drop",  64'(bus.drop_cnt), 64'(exp_drop));

        // Fill, then 300 drops to saturate the drop counter.
        drive(0, 0, 0, 1, 0, 39'h0, 39'h0, 0, 0, 2'd0);
        step();
        for (int k = 0; k < 4 + 300; k++) begin
            drive(1, 0, 0, 0, 0, 39'h8000 + 39'(k), 39'h0, 1, 1, 2'd1);
            step();
        end
        chk("sat_count", 64'(bus.count), 64'd4);
        chk("sat_drop",  64'(bus.drop_cnt), 64'd255);

        // Counter boundaries at the head, each after a flush.
        drive(0, 0, 0, 1, 0, 39'h0, 39'h0, 0, 0, 2'd0);
        step();
        chk("flush_keeps_drop", 64'(bus.drop_cnt), 64'd255);
        chk("flush_count",      64'(bus.count), 64'd0);
        drive(1, 0, 0, 0, 0, 39'h9000, 39'h0, 1, 1, 2'd3);
        step();
        chk("bim3_taken", 64'(bus.train_bim_next), 64'd3);
        drive(0, 0, 0, 1, 0, 39'h0, 39'h0, 0, 0, 2'd0);
        step();
        drive(1, 0, 0, 0, 0, 39'h9004, 39'h0, 0, 1, 2'd0);
        step();
        chk("bim0_not_taken", 64'(bus.train_bim_next), 64'd0);
        drive(0, 0, 0, 1, 0, 39'h0, 39'h0, 0, 0, 2'd0);
        step();
        drive(1, 0, 0, 0, 0, 39'h9008, 39'h0, 0, 0, 2'd1);
        step();
        chk("uncond_bim", 64'(bus.train_bim_next), 64'd3);
        // Holding with ready low keeps the head stable.
        drive(0, 0, 0, 0, 0, 39'h0, 39'h0, 0, 0, 2'd0);
        step();
        chk("hold_head_pc", 64'(bus.train_pc_vaddr), 64'h9008);
        chk("hold_count",   64'(bus.count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
